uart_rx_cfg: RTL and testbench

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_rx_cfg.sv | 173 +++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver.
// The bit-period helper is evaluated at elaboration time only.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_e;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  function automatic logic [31:0] clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
    return 32'(clk_freq / baud_rate);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit; 2-cycle latency, no backpressure.
// Both flops reset to RST_VAL so the output is defined from the first cycle.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with optional parity and 1/2 stop bits; word is valid one cycle
// after the last stop sample and held until valid&ready; a word arriving while held is dropped.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam logic [31:0] CPB     = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam logic [31:0] HALF_M1 = CPB / 2 - 32'd1;
  localparam logic [31:0] FULL_M1 = CPB - 32'd1;
  localparam logic [3:0]  DB_M1   = 4'(DATA_BITS - 1);
  localparam logic [3:0]  SB_M1   = 4'(STOP_BITS - 1);

  logic rx_s;
  logic rx_prev_q;

  state_e               state_q, state_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 pe_q, pe_d;
  logic                 fe_q, fe_d;
  logic                 word_done;

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 32'd1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    pe_d      = pe_q;
    fe_d      = fe_q;
    word_done = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // A line held low (break) never yields prev=1/cur=0, so no restart until it rises.
        if (rx_en && rx_prev_q && !rx_s) begin
          state_d = START;
          bit_d   = '0;
          pe_d    = 1'b0;
          fe_d    = 1'b0;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_q == DB_M1) begin
            bit_d   = '0;
            state_d = (PARITY != PARITY_NONE) ? PAR : STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      PAR: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = STOP;
          pe_d    = (PARITY == PARITY_EVEN) ? (^shift_q ^ rx_s) : ~(^shift_q ^ rx_s);
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (!rx_s) fe_d = 1'b1;
          if (bit_q == SB_M1) begin
            bit_d     = '0;
            state_d   = IDLE;
            word_done = 1'b1;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d       = data_q;
    valid_d      = valid_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = overrun_q;
    if (word_done && (!valid_q || ready)) begin
      data_d       = shift_q;
      valid_d      = 1'b1;
      frame_err_d  = fe_d;
      parity_err_d = pe_q;
      overrun_d    = 1'b0;
    end else if (word_done) begin
      overrun_d = 1'b1;
    end else if (valid_q && ready) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_prev_q    <= 1'b1;
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      pe_q         <= 1'b0;
      fe_q         <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_prev_q    <= rx_s;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      pe_q         <= pe_d;
      fe_q         <= fe_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: an 8N1 instance (a) and an 8E1 instance (b), 434 clocks per bit.
module tb_uart_rx_cfg;

  localparam int CPB = 434;

  logic clk = 1'b0;
  logic rst;
  logic rx_en;
  logic rx_a, rx_b;
  logic ready_a, ready_b;

  logic [7:0] data_a, data_b;
  logic valid_a, valid_b, fe_a, fe_b, pe_a, pe_b, ovr_a, ovr_b, busy_a, busy_b;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] cap_a_data, cap_b_data;
  logic       cap_a_fe, cap_a_pe, cap_b_fe, cap_b_pe;
  int         vld_a_n = 0;
  int         vld_b_n = 0;

  always #10 clk = ~clk;

  uart_rx_cfg u_a (
    .clk(clk), .rst(rst), .rx_en(rx_en), .rx(rx_a),
    .data(data_a), .valid(valid_a), .ready(ready_a),
    .frame_err(fe_a), .parity_err(pe_a), .overrun(ovr_a), .busy(busy_a)
  );

  uart_rx_cfg #(.PARITY(1)) u_b (
    .clk(clk), .rst(rst), .rx_en(rx_en), .rx(rx_b),
    .data(data_b), .valid(valid_b), .ready(ready_b),
    .frame_err(fe_b), .parity_err(pe_b), .overrun(ovr_b), .busy(busy_b)
  );

  // Capture every cycle a word is presented, away from the active edge.
  always @(negedge clk) begin
    if (valid_a) begin
      cap_a_data <= data_a;
      cap_a_fe   <= fe_a;
      cap_a_pe   <= pe_a;
      vld_a_n    <= vld_a_n + 1;
    end
    if (valid_b) begin
      cap_b_data <= data_b;
      cap_b_fe   <= fe_b;
      cap_b_pe   <= pe_b;
      vld_b_n    <= vld_b_n + 1;
    end
  end

  typedef struct {
    logic [7:0] tx;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_fe;
  } vec_t;

  vec_t tbl [4];

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_line(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  // Full frame; the line is left at the stop value so a bad stop can continue as a break.
  task automatic send(input bit sel, input logic [7:0] b, input bit use_par,
                      input logic pbit, input logic stop_v);
    set_line(sel, 1'b0);
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      set_line(sel, b[i]);
      cyc(CPB);
    end
    if (use_par) begin
      set_line(sel, pbit);
      cyc(CPB);
    end
    set_line(sel, stop_v);
    cyc(CPB);
  endtask

  initial begin
    int base;
    int nb;

    tbl[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
    tbl[1] = '{8'h00, 1'b1, 8'h00, 1'b0};
    tbl[2] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
    tbl[3] = '{8'h81, 1'b0, 8'h81, 1'b1};

    rst = 1'b1; rx_en = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
    ready_a = 1'b1; ready_b = 1'b1;
    cyc(3);
    chk("reset_a", {data_a, valid_a, fe_a, pe_a, ovr_a, busy_a}, 32'h0);
    chk("reset_b", {data_b, valid_b, fe_b, pe_b, ovr_b, busy_b}, 32'h0);
    rst = 1'b0;
    cyc(5);

    for (int v = 0; v < 4; v++) begin
      base = vld_a_n;
      send(1'b0, tbl[v].tx, 1'b0, 1'b0, tbl[v].stop);
      set_line(1'b0, 1'b1);
      cyc(2);
      chk($sformatf("tbl%0d_data", v), cap_a_data, tbl[v].exp_data);
      chk($sformatf("tbl%0d_fe", v), cap_a_fe, tbl[v].exp_fe);
      chk($sformatf("tbl%0d_pe", v), cap_a_pe, 0);
      chk($sformatf("tbl%0d_vld_cycles", v), vld_a_n - base, 1);
      cyc(CPB);
    end

    // Bad stop followed by a held-low line: no start may be seen until it rises.
    base = vld_a_n;
    send(1'b0, 8'h7E, 1'b0, 1'b0, 1'b0);
    cyc(2);
    chk("brk_data", cap_a_data, 8'h7E);
    chk("brk_fe", cap_a_fe, 1);
    chk("brk_vld", vld_a_n - base, 1);
    nb = 0;
    for (int i = 0; i < 3000; i++) begin
      cyc(1);
      if (busy_a) nb++;
    end
    chk("brk_no_start", nb, 0);
    set_line(1'b0, 1'b1);
    cyc(2 * CPB);
    send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    cyc(2);
    chk("after_brk_data", cap_a_data, 8'h3C);
    chk("after_brk_fe", cap_a_fe, 0);

    // 100-clock glitch: false start, busy back low 220 clocks after the edge.
    base = vld_a_n;
    rx_a = 1'b0;
    cyc(10);
    chk("glitch_busy_hi", busy_a, 1);
    cyc(90);
    rx_a = 1'b1;
    cyc(120);
    chk("glitch_busy_lo", busy_a, 0);
    cyc(2 * CPB);
    chk("glitch_no_valid", vld_a_n - base, 0);

    // Overrun: second word dropped while the first is held.
    ready_a = 1'b0;
    send(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    cyc(2);
    chk("ovr_first", {valid_a, data_a, ovr_a}, {1'b1, 8'h11, 1'b0});
    send(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    cyc(2);
    chk("ovr_second", {valid_a, data_a, ovr_a}, {1'b1, 8'h11, 1'b1});
    ready_a = 1'b1;
    cyc(1);
    ready_a = 1'b0;
    chk("ovr_accept", {valid_a, ovr_a}, 2'b00);
    ready_a = 1'b1;

    // Reset in the middle of the data bits.
    base = vld_a_n;
    rx_a = 1'b0;
    cyc(CPB * 3);
    chk("mid_busy", busy_a, 1);
    rst = 1'b1;
    cyc(1);
    chk("mid_rst_outs", {data_a, valid_a, fe_a, pe_a, ovr_a, busy_a}, 32'h0);
    rx_a = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(CPB * 10);
    chk("mid_rst_no_word", vld_a_n - base, 0);
    send(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    cyc(2);
    chk("post_rst_data", cap_a_data, 8'h5A);
    chk("post_rst_flags", {cap_a_fe, cap_a_pe}, 2'b00);
    chk("post_rst_vld", vld_a_n - base, 1);

    // Even parity instance.
    send(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
    cyc(2);
    chk("par03_1", {cap_b_data, cap_b_pe, cap_b_fe}, {8'h03, 1'b1, 1'b0});
    send(1'b1, 8'h03, 1'b1, 1'b0, 1'b1);
    cyc(2);
    chk("par03_0", {cap_b_data, cap_b_pe, cap_b_fe}, {8'h03, 1'b0, 1'b0});
    send(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    cyc(2);
    chk("par07_0", {cap_b_data, cap_b_pe, cap_b_fe}, {8'h07, 1'b1, 1'b0});
    chk("par_vld_count", vld_b_n, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
